// File: rtl/wb_stage.sv
// Writeback stage: commits ALU results and aligned load data to the register file,
// tracks the outstanding load for hazard logic, and keeps sticky error flags.
module wb_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_wen,
    input  logic        in_is_load,
    input  logic [2:0]  in_funct3,
    input  logic [1:0]  in_addr_lo,
    input  logic [31:0] in_alu_result,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wr_regfile,
    output logic [31:0] wr_regfile_data,
    output logic [4:0]  rd,
    output logic        fwd_valid,
    output logic        load_pending,
    output logic [4:0]  pend_rd,
    output logic [31:0] retired,
    output logic        err_misalign,
    output logic        err_timeout,
    output logic        err_spurious
);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  rd_q, rd_d;
    logic        wen_q, wen_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  addr_q, addr_d;
    logic        mis_q, mis_d;
    logic        wr_q, wr_d;
    logic [31:0] data_q, data_d;
    logic        in_ready_q, in_ready_d;
    logic        ld_pend_q, ld_pend_d;
    logic [31:0] retired_q, retired_d;
    logic        err_mis_q, err_mis_d;
    logic        err_to_q, err_to_d;
    logic        err_sp_q, err_sp_d;

    logic        accept;
    logic        in_mis;
    logic [7:0]  cnt_inc;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign accept  = in_valid && in_ready_q;
    assign cnt_inc = cnt_q + 8'd1;

    // funct3[1:0]: 00 byte, 01 half, 1x word (includes the undefined encodings)
    assign in_mis = ((in_funct3[1:0] == 2'b01) && in_addr_lo[0]) ||
                    (in_funct3[1] && (in_addr_lo != 2'b00));

    always_comb begin
        case (addr_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        wen_d     = wen_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        mis_d     = mis_q;
        wr_d      = 1'b0;
        data_d    = data_q;
        retired_d = retired_q;
        err_mis_d = err_mis_q;
        err_to_d  = err_to_q;
        err_sp_d  = err_sp_q;

        case (state_q)
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d = COMMIT;
                    data_d  = load_data;
                    wr_d    = wen_q && (rd_q != 5'd0) && !mis_q;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    state_d  = IDLE;
                    err_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    rd_d  = in_rd;
                    wen_d = in_wen;
                    if (in_is_load) begin
                        state_d = WAIT_MEM;
                        f3_d    = in_funct3;
                        addr_d  = in_addr_lo;
                        mis_d   = in_mis;
                        cnt_d   = '0;
                        if (in_mis) err_mis_d = 1'b1;
                    end else begin
                        state_d = COMMIT;
                        mis_d   = 1'b0;
                        data_d  = in_alu_result;
                        wr_d    = in_wen && (in_rd != 5'd0);
                    end
                end
            end
        endcase

        if (mem_rvalid && (state_q != WAIT_MEM)) err_sp_d = 1'b1;
        if (state_d == COMMIT) retired_d = retired_q + 32'd1;
        in_ready_d = (state_d != WAIT_MEM);
        ld_pend_d  = (state_d == WAIT_MEM);
    end

    always_ff @(posedge CLK or posedge RST_X) begin
        if (RST_X) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_q       <= '0;
            wen_q      <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            mis_q      <= 1'b0;
            wr_q       <= 1'b0;
            data_q     <= '0;
            in_ready_q <= 1'b1;
            ld_pend_q  <= 1'b0;
            retired_q  <= '0;
            err_mis_q  <= 1'b0;
            err_to_q   <= 1'b0;
            err_sp_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wen_q      <= wen_d;
            f3_q       <= f3_d;
            addr_q     <= addr_d;
            mis_q      <= mis_d;
            wr_q       <= wr_d;
            data_q     <= data_d;
            in_ready_q <= in_ready_d;
            ld_pend_q  <= ld_pend_d;
            retired_q  <= retired_d;
            err_mis_q  <= err_mis_d;
            err_to_q   <= err_to_d;
            err_sp_q   <= err_sp_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign wr_regfile      = wr_q;
    assign fwd_valid       = wr_q;
    assign wr_regfile_data = data_q;
    assign rd              = rd_q;
    assign pend_rd         = rd_q;
    assign load_pending    = ld_pend_q;
    assign retired         = retired_q;
    assign err_misalign    = err_mis_q;
    assign err_timeout     = err_to_q;
    assign err_spurious    = err_sp_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with TIMEOUT=4; outputs are sampled 1ns after each posedge.
module tb_wb_stage;

    logic        CLK = 1'b0;
    logic        RST_X = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic        in_wen = 1'b0;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [1:0]  in_addr_lo = '0;
    logic [31:0] in_alu_result = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wr_regfile;
    logic [31:0] wr_regfile_data;
    logic [4:0]  rd;
    logic        fwd_valid;
    logic        load_pending;
    logic [4:0]  pend_rd;
    logic [31:0] retired;
    logic        err_misalign;
    logic        err_timeout;
    logic        err_spurious;

    int passed = 0;
    int total  = 0;

    wb_stage #(.TIMEOUT(4)) dut (
        .CLK(CLK), .RST_X(RST_X),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_wen(in_wen), .in_is_load(in_is_load),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wr_regfile(wr_regfile), .wr_regfile_data(wr_regfile_data), .rd(rd),
        .fwd_valid(fwd_valid), .load_pending(load_pending), .pend_rd(pend_rd),
        .retired(retired), .err_misalign(err_misalign),
        .err_timeout(err_timeout), .err_spurious(err_spurious)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_is_load = 1'b0; mem_rvalid = 1'b0;
        RST_X = 1'b1;
        tick();
        tick();
        RST_X = 1'b0;
    endtask

    task automatic drive_op(input logic ld, input logic [4:0] r, input logic [2:0] f3,
                            input logic [1:0] a, input logic [31:0] alu);
        in_valid = 1'b1; in_is_load = ld; in_rd = r; in_wen = 1'b1;
        in_funct3 = f3; in_addr_lo = a; in_alu_result = alu;
    endtask

    task automatic test_reset();
        RST_X = 1'b1;
        tick();
        total++; if ({in_ready, wr_regfile, fwd_valid, load_pending} !== 4'b1000) $display("FAIL reset_ctrl got %b want 1000", {in_ready, wr_regfile, fwd_valid, load_pending}); else passed++;
        total++; if (retired !== 32'd0 || wr_regfile_data !== 32'd0 || rd !== 5'd0) $display("FAIL reset_data got ret=%0d data=%h rd=%0d want 0", retired, wr_regfile_data, rd); else passed++;
        total++; if ({err_misalign, err_timeout, err_spurious} !== 3'b000) $display("FAIL reset_err got %b want 000", {err_misalign, err_timeout, err_spurious}); else passed++;
        RST_X = 1'b0;
    endtask

    task automatic test_nonload();
        do_reset();
        drive_op(1'b0, 5'd5, 3'd0, 2'd0, 32'h12345678);
        tick();
        in_valid = 1'b0;
        total++; if (wr_regfile !== 1'b1 || fwd_valid !== 1'b1 || rd !== 5'd5) $display("FAIL nl_write got wr=%b fwd=%b rd=%0d want 1 1 5", wr_regfile, fwd_valid, rd); else passed++;
        total++; if (wr_regfile_data !== 32'h12345678 || retired !== 32'd1) $display("FAIL nl_data got %h ret=%0d want 12345678 1", wr_regfile_data, retired); else passed++;
        tick();
        total++; if (wr_regfile !== 1'b0 || retired !== 32'd1 || in_ready !== 1'b1) $display("FAIL nl_after got wr=%b ret=%0d rdy=%b want 0 1 1", wr_regfile, retired, in_ready); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] rds [3] = '{5'd1, 5'd2, 5'd0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_op(1'b0, rds[i], 3'd0, 2'd0, 32'hA0 + 32'(i));
            tick();
            total++;
            if (wr_regfile !== (rds[i] != 5'd0) || rd !== rds[i] || retired !== 32'(i + 1) ||
                (rds[i] != 5'd0 && wr_regfile_data !== 32'hA0 + 32'(i)))
                $display("FAIL b2b_%0d got wr=%b rd=%0d ret=%0d data=%h", i, wr_regfile, rd, retired, wr_regfile_data);
            else passed++;
        end
        in_valid = 1'b0;
        tick();
        total++; if (wr_regfile !== 1'b0 || retired !== 32'd3) $display("FAIL b2b_end got wr=%b ret=%0d want 0 3", wr_regfile, retired); else passed++;
    endtask

    task automatic test_load_wait();
        do_reset();
        drive_op(1'b1, 5'd7, 3'b000, 2'd3, 32'd0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (load_pending !== 1'b1 || pend_rd !== 5'd7 || in_ready !== 1'b0 || wr_regfile !== 1'b0) $display("FAIL ld_pend_%0d got lp=%b prd=%0d rdy=%b wr=%b", i, load_pending, pend_rd, in_ready, wr_regfile); else passed++;
            if (i == 3) begin mem_rvalid = 1'b1; mem_rdata = 32'h80FFFF00; end
            tick();
        end
        mem_rvalid = 1'b0;
        total++; if (wr_regfile !== 1'b1 || wr_regfile_data !== 32'hFFFFFF80 || rd !== 5'd7) $display("FAIL lb_commit got wr=%b data=%h rd=%0d want 1 ffffff80 7", wr_regfile, wr_regfile_data, rd); else passed++;
        total++; if (load_pending !== 1'b0 || in_ready !== 1'b1 || retired !== 32'd1) $display("FAIL lb_status got lp=%b rdy=%b ret=%0d want 0 1 1", load_pending, in_ready, retired); else passed++;
    endtask

    typedef struct { logic [2:0] f3; logic [1:0] a; logic [31:0] w; logic [31:0] exp; } ld_vec_t;

    task automatic test_align();
        ld_vec_t v [11] = '{
            '{3'b000, 2'd3, 32'h80FFFF00, 32'hFFFFFF80},
            '{3'b100, 2'd2, 32'h80FFFF00, 32'h000000FF},
            '{3'b000, 2'd1, 32'h80FFFF00, 32'hFFFFFFFF},
            '{3'b100, 2'd0, 32'h80FFFF00, 32'h00000000},
            '{3'b001, 2'd0, 32'h80FFFF00, 32'hFFFFFF00},
            '{3'b101, 2'd2, 32'h80FFFF00, 32'h000080FF},
            '{3'b001, 2'd2, 32'h80FFFF00, 32'hFFFF80FF},
            '{3'b010, 2'd0, 32'h80FFFF00, 32'h80FFFF00},
            '{3'b011, 2'd0, 32'h80FFFF00, 32'h80FFFF00},
            '{3'b000, 2'd1, 32'h12345678, 32'h00000056},
            '{3'b101, 2'd0, 32'h12345678, 32'h00005678}};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive_op(1'b1, 5'd9, v[i].f3, v[i].a, 32'd0);
            tick();
            in_valid = 1'b0;
            mem_rvalid = 1'b1; mem_rdata = v[i].w;
            tick();
            mem_rvalid = 1'b0;
            total++; if (wr_regfile !== 1'b1 || wr_regfile_data !== v[i].exp) $display("FAIL align_%0d got wr=%b data=%h want 1 %h", i, wr_regfile, wr_regfile_data, v[i].exp); else passed++;
        end
        total++; if (retired !== 32'd11 || err_misalign !== 1'b0 || err_spurious !== 1'b0) $display("FAIL align_end got ret=%0d mis=%b sp=%b want 11 0 0", retired, err_misalign, err_spurious); else passed++;
    endtask

    task automatic test_misalign();
        do_reset();
        drive_op(1'b1, 5'd4, 3'b010, 2'd1, 32'd0);
        tick();
        in_valid = 1'b0;
        total++; if (err_misalign !== 1'b1 || load_pending !== 1'b1) $display("FAIL mis_flag got mis=%b lp=%b want 1 1", err_misalign, load_pending); else passed++;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_rvalid = 1'b0;
        total++; if (wr_regfile !== 1'b0 || retired !== 32'd1 || in_ready !== 1'b1) $display("FAIL mis_commit got wr=%b ret=%0d rdy=%b want 0 1 1", wr_regfile, retired, in_ready); else passed++;
        drive_op(1'b1, 5'd4, 3'b001, 2'd1, 32'd0);
        tick();
        in_valid = 1'b0;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        total++; if (wr_regfile !== 1'b0 || retired !== 32'd2 || err_misalign !== 1'b1) $display("FAIL mis_lh got wr=%b ret=%0d mis=%b want 0 2 1", wr_regfile, retired, err_misalign); else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        drive_op(1'b1, 5'd3, 3'b010, 2'd0, 32'd0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        total++; if (err_timeout !== 1'b0 || load_pending !== 1'b1) $display("FAIL to_early got to=%b lp=%b want 0 1", err_timeout, load_pending); else passed++;
        tick();
        total++; if (err_timeout !== 1'b1 || load_pending !== 1'b0 || in_ready !== 1'b1 || wr_regfile !== 1'b0 || retired !== 32'd0) $display("FAIL to_fire got to=%b lp=%b rdy=%b wr=%b ret=%0d", err_timeout, load_pending, in_ready, wr_regfile, retired); else passed++;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        total++; if (err_spurious !== 1'b1 || wr_regfile !== 1'b0) $display("FAIL to_spur got sp=%b wr=%b want 1 0", err_spurious, wr_regfile); else passed++;
        // data arriving on the final allowed edge beats the timeout
        do_reset();
        drive_op(1'b1, 5'd3, 3'b010, 2'd0, 32'd0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
        tick();
        mem_rvalid = 1'b0;
        total++; if (wr_regfile !== 1'b1 || wr_regfile_data !== 32'h0BADF00D || err_timeout !== 1'b0) $display("FAIL to_race got wr=%b data=%h to=%b want 1 0badf00d 0", wr_regfile, wr_regfile_data, err_timeout); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_op(1'b1, 5'd6, 3'b010, 2'd2, 32'd0);
        tick();
        in_valid = 1'b0;
        tick();
        #2 RST_X = 1'b1;
        #1;
        total++; if ({in_ready, load_pending, wr_regfile, err_misalign, err_timeout, err_spurious} !== 6'b100000 || pend_rd !== 5'd0 || retired !== 32'd0) $display("FAIL rst_mid got %b prd=%0d ret=%0d want 100000 0 0", {in_ready, load_pending, wr_regfile, err_misalign, err_timeout, err_spurious}, pend_rd, retired); else passed++;
        tick();
        RST_X = 1'b0;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        total++; if (wr_regfile !== 1'b0 || err_spurious !== 1'b1 || retired !== 32'd0) $display("FAIL rst_spur got wr=%b sp=%b ret=%0d want 0 1 0", wr_regfile, err_spurious, retired); else passed++;
    endtask

    initial begin
        test_reset();
        test_nonload();
        test_back_to_back();
        test_load_wait();
        test_align();
        test_misalign();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
